// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, runs a req/ack handshake to instruction memory and drives the
// IF/ID registers. A one-entry skid buffer absorbs a fetch that completes while
// decode is stalled; flush redirects the PC and drops anything in flight.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/bubble performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_vld
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_vld_q, id_vld_d;
    logic        xfer;
    logic        land;
    logic        bubble;

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign xfer      = imem_req && imem_ack;

    assign id_pc   = id_pc_q;
    assign id_inst = id_inst_q;
    assign id_vld  = id_vld_q;

    // Next-state logic: flush overrides everything except reset; otherwise the
    // state decides between fetching, skid-buffering and releasing the buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_vld_d   = id_vld_q;
        land       = 1'b0;
        bubble     = 1'b0;
        if (flush) begin
            pc_d      = flush_pc & 32'hFFFF_FFFC;
            id_vld_d  = 1'b0;
            id_inst_d = NOP_INST;
            state_d   = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (xfer && !stall) begin
                        id_pc_d   = pc_q;
                        id_inst_d = imem_rdata;
                        id_vld_d  = 1'b1;
                        pc_d      = pc_q + 32'd4;
                        land      = 1'b1;
                    end else if (xfer) begin
                        buf_pc_d   = pc_q;
                        buf_inst_d = imem_rdata;
                        pc_d       = pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end else if (!stall) begin
                        id_vld_d  = 1'b0;
                        id_inst_d = NOP_INST;
                        bubble    = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_pc_d   = buf_pc_q;
                        id_inst_d = buf_inst_q;
                        id_vld_d  = 1'b1;
                        land      = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            buf_pc_q   <= 32'h0;
            buf_inst_q <= NOP_INST;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_INST;
            id_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_vld_q   <= id_vld_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;

    // Saturating counters of delivered instructions and fetch bubbles.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (land && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage.
// A transaction-level reference model tracks the PC, the queue of fetched but
// not yet presented instructions and the decode-side view; the expected
// post-edge outputs are queued and a separate monitor pops and compares them.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk;
    logic        rst_;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_vld;

    if_stage #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .stall     (stall),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_vld    (id_vld)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] idPc;
        logic [31:0] idInst;
        logic        idVld;
    } expect_t;

    expect_t     expQ[$];
    item_t       mFetched[$];
    logic [31:0] mPc;
    logic [31:0] mIdPc;
    logic [31:0] mIdInst;
    logic        mIdVld;
    bit          mStarted;
    logic [31:0] memKey;
    int          vectors;
    int          miscompares;
    int          cycleNo;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a keyed hash of the address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return memKey ^ {addr[15:0], ~addr[31:16]} ^ (addr * 32'h9E37_79B1);
    endfunction

    // Reference model: one clock edge worth of fetch-stage behaviour.
    task automatic modelStep(input bit rstn, input bit stallV, input bit flushV,
                             input logic [31:0] fpc, input bit ackV);
        bit    reqNow;
        item_t it;
        if (!rstn) begin
            mPc      = RESET_PC;
            mIdPc    = 32'h0;
            mIdInst  = NOP_INST;
            mIdVld   = 1'b0;
            mStarted = 1'b0;
            mFetched.delete();
        end else begin
            reqNow = mStarted && (mFetched.size() == 0);
            if (flushV) begin
                mFetched.delete();
                mPc      = {fpc[31:2], 2'b00};
                mIdVld   = 1'b0;
                mIdInst  = NOP_INST;
                mStarted = 1'b1;
            end else if (!mStarted) begin
                mStarted = 1'b1;
            end else if (reqNow && ackV) begin
                it.pc   = mPc;
                it.inst = memWord(mPc);
                mPc     = mPc + 32'd4;
                if (stallV) begin
                    mFetched.push_back(it);
                end else begin
                    mIdPc   = it.pc;
                    mIdInst = it.inst;
                    mIdVld  = 1'b1;
                end
            end else if ((mFetched.size() > 0) && !stallV) begin
                it      = mFetched.pop_front();
                mIdPc   = it.pc;
                mIdInst = it.inst;
                mIdVld  = 1'b1;
            end else if (reqNow && !stallV) begin
                mIdVld  = 1'b0;
                mIdInst = NOP_INST;
            end
        end
    endtask

    // Drive one cycle of inputs, step the model and queue the expected result.
    task automatic applyStimulus(input bit rstn, input bit stallV, input bit flushV,
                                 input logic [31:0] fpc, input bit ackV);
        expect_t e;
        @(negedge clk);
        #1;
        rst_     = rstn;
        stall    = stallV;
        flush    = flushV;
        flush_pc = fpc;
        imem_ack = ackV;
        if (ackV) begin
            imem_rdata = memWord(imem_addr);
        end else begin
            imem_rdata = $urandom;
        end
        modelStep(rstn, stallV, flushV, fpc, ackV);
        e.req    = mStarted && (mFetched.size() == 0);
        e.addr   = mPc;
        e.idPc   = mIdPc;
        e.idInst = mIdInst;
        e.idVld  = mIdVld;
        expQ.push_back(e);
    endtask

    // One scored comparison.
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycleNo, got, exp);
        end
    endtask

    // Monitor: after every edge compare the DUT against the queued expectation.
    initial begin
        expect_t e;
        cycleNo = 0;
        forever begin
            @(posedge clk);
            #2;
            cycleNo++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("imem_req",  {31'h0, imem_req}, {31'h0, e.req});
                checkOutput("imem_addr", imem_addr, e.addr);
                checkOutput("id_pc",     id_pc,     e.idPc);
                checkOutput("id_inst",   id_inst,   e.idInst);
                checkOutput("id_vld",    {31'h0, id_vld}, {31'h0, e.idVld});
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        bit          r;
        bit          s;
        bit          f;
        bit          a;
        logic [31:0] p;
        vectors     = 0;
        miscompares = 0;
        memKey      = $urandom;
        rst_        = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;

        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        // Back-to-back fetches with ack held high from reset release.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // Ack gap of three cycles at pc 0x8.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // Stall on the ack of pc 0x10, held, then released.
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // Flush to a misaligned target while holding a buffered instruction.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1003, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // Flush coinciding with an ack.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // PC wrap-around from the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        // Reset arriving while a fetch sits in the skid buffer.
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 9) < 7);
            p = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                p = 32'hFFFF_FFF0 | (p & 32'hF);
            end
            applyStimulus(r, s, f, p, a);
        end

        repeat (2) @(posedge clk);
        #5;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
